// File: rtl/system_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_types_pkg
// Description : Shared dcache write-buffer types, sizes and byte-merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package system_types_pkg;

  localparam int PA_WIDTH                  = 32;
  localparam int DCACHE_BLOCK_OFFSET_WIDTH = 5;
  localparam int DCACHE_WB_DEPTH           = 8;
  localparam int DCACHE_NUM_BANKS          = 2;

  typedef struct packed {
    logic [PA_WIDTH-3:0] pa_word;
    logic [31:0]         data;
    logic [3:0]          byte_mask;
  } dcache_wb_entry_t;

  // Bytes enabled in new_mask take new_data; the rest keep old_data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  new_mask);
    logic [31:0] merged;
    merged = old_data;
    for (int b = 0; b < 4; b++) begin
      if (new_mask[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_wb_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wb_fwd_select
// Description : Per-byte youngest-match store-to-load forwarding selector.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_wb_fwd_select
  import system_types_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  dcache_wb_entry_t            i_entries [DEPTH],
  input  logic [DEPTH-1:0]            i_valid,
  input  logic [$clog2(DEPTH)-1:0]    i_head,
  input  logic [PA_WIDTH-3:0]         i_lookup_word,
  output logic [3:0]                  o_fwd_byte_mask,
  output logic [31:0]                 o_fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match written for a byte is the youngest.
  always_comb begin
    o_fwd_byte_mask = '0;
    o_fwd_data      = '0;
    w_idx           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if (i_valid[w_idx] && (i_entries[w_idx].pa_word == i_lookup_word)) begin
        for (int b = 0; b < 4; b++) begin
          if (i_entries[w_idx].byte_mask[b]) begin
            o_fwd_byte_mask[b]   = 1'b1;
            o_fwd_data[8*b +: 8] = i_entries[w_idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_banked_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dcache_banked_write_buffer
// Description : In-order store buffer draining to banked dcache, with load
//               forwarding. Define DCACHE_WB_COALESCE_EN to merge same-word
//               stores into the youngest non-head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_banked_write_buffer
  import system_types_pkg::*;
#(
  parameter int DEPTH     = DCACHE_WB_DEPTH,
  parameter int NUM_BANKS = DCACHE_NUM_BANKS
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PA_WIDTH-1:0]        enq_PA,
  input  logic [31:0]                enq_data,
  input  logic [3:0]                 enq_byte_mask,
  output logic [NUM_BANKS-1:0]       bank_req_valid,
  input  logic [NUM_BANKS-1:0]       bank_req_ready,
  output logic [PA_WIDTH-1:0]        bank_req_PA,
  output logic [31:0]                bank_req_data,
  output logic [3:0]                 bank_req_byte_mask,
  input  logic [PA_WIDTH-1:0]        fwd_PA,
  output logic [3:0]                 fwd_byte_mask,
  output logic [31:0]                fwd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  dcache_wb_entry_t    r_entries [DEPTH];
  logic [DEPTH-1:0]    r_valid;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  dcache_wb_entry_t    w_head_entry;
  logic [BANK_W-1:0]   w_head_bank;
  logic [PA_WIDTH-3:0] w_enq_word;
  logic                w_coalesce_hit;
  logic                w_enq_fire;
  logic                w_alloc;
  logic                w_deq;
  logic                w_unused_pa_lsbs;

  assign w_head_entry     = r_entries[r_head];
  assign w_enq_word       = enq_PA[PA_WIDTH-1:2];
  assign w_unused_pa_lsbs = ^{enq_PA[1:0], fwd_PA[1:0]};

  generate
    if (NUM_BANKS > 1) begin : g_multi_bank
      // pa_word drops PA[1:0], hence the -2 on the block offset.
      assign w_head_bank = w_head_entry.pa_word[DCACHE_BLOCK_OFFSET_WIDTH-2 +: BANK_W];
    end else begin : g_single_bank
      assign w_head_bank = '0;
    end
  endgenerate

`ifdef DCACHE_WB_COALESCE_EN
  logic [PTR_W-1:0]  w_youngest_idx;
  dcache_wb_entry_t  w_youngest;
  dcache_wb_entry_t  w_merged;

  assign w_youngest_idx = r_tail - PTR_W'(1);
  assign w_youngest     = r_entries[w_youngest_idx];
  // The head may be draining this cycle, so it is never a merge target.
  assign w_coalesce_hit = (r_count != '0) && (w_youngest_idx != r_head) &&
                          (w_youngest.pa_word == w_enq_word);

  always_comb begin
    w_merged           = w_youngest;
    w_merged.data      = merge_bytes(w_youngest.data, enq_data, enq_byte_mask);
    w_merged.byte_mask = w_youngest.byte_mask | enq_byte_mask;
  end
`else
  assign w_coalesce_hit = 1'b0;
`endif

  assign enq_ready  = (r_count < CNT_W'(DEPTH)) | w_coalesce_hit;
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_alloc    = w_enq_fire & ~w_coalesce_hit;

  always_comb begin
    bank_req_valid = '0;
    if (r_count != '0) bank_req_valid[w_head_bank] = 1'b1;
  end

  assign w_deq              = |(bank_req_valid & bank_req_ready);
  assign bank_req_PA        = {w_head_entry.pa_word, 2'b00};
  assign bank_req_data      = w_head_entry.data;
  assign bank_req_byte_mask = w_head_entry.byte_mask;
  assign empty              = (r_count == '0);
  assign count              = r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else begin
      if (w_alloc) begin
        r_entries[r_tail] <= '{pa_word: w_enq_word, data: enq_data, byte_mask: enq_byte_mask};
        r_valid[r_tail]   <= 1'b1;
        r_tail            <= r_tail + PTR_W'(1);
      end
`ifdef DCACHE_WB_COALESCE_EN
      if (w_enq_fire && w_coalesce_hit) r_entries[w_youngest_idx] <= w_merged;
`endif
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      case ({w_alloc, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  dcache_wb_fwd_select #(
    .DEPTH (DEPTH)
  ) u_fwd_select (
    .i_entries       (r_entries),
    .i_valid         (r_valid),
    .i_head          (r_head),
    .i_lookup_word   (fwd_PA[PA_WIDTH-1:2]),
    .o_fwd_byte_mask (fwd_byte_mask),
    .o_fwd_data      (fwd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_dcache_banked_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_banked_write_buffer
// Description : Scoreboard bench for the banked dcache write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_banked_write_buffer;
  import system_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_PA;
  logic [31:0] enq_data;
  logic [3:0]  enq_byte_mask;
  logic [1:0]  bank_req_valid;
  logic [1:0]  bank_req_ready;
  logic [31:0] bank_req_PA;
  logic [31:0] bank_req_data;
  logic [3:0]  bank_req_byte_mask;
  logic [31:0] fwd_PA;
  logic [3:0]  fwd_byte_mask;
  logic [31:0] fwd_data;
  logic        empty;
  logic [3:0]  count;

  typedef struct {
    logic [31:0] pa;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  dcache_banked_write_buffer #(.DEPTH(8), .NUM_BANKS(2)) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .enq_valid          (enq_valid),
    .enq_ready          (enq_ready),
    .enq_PA             (enq_PA),
    .enq_data           (enq_data),
    .enq_byte_mask      (enq_byte_mask),
    .bank_req_valid     (bank_req_valid),
    .bank_req_ready     (bank_req_ready),
    .bank_req_PA        (bank_req_PA),
    .bank_req_data      (bank_req_data),
    .bank_req_byte_mask (bank_req_byte_mask),
    .fwd_PA             (fwd_PA),
    .fwd_byte_mask      (fwd_byte_mask),
    .fwd_data           (fwd_data),
    .empty              (empty),
    .count              (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [31:0] pa, input logic [31:0] d, input logic [3:0] m);
    exp_t e;
    e.pa = pa; e.data = d; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic enq(input logic [31:0] pa, input logic [31:0] d, input logic [3:0] m);
    chk("enq_ready_before_enq", 64'(enq_ready), 64'(1));
    enq_valid = 1'b1; enq_PA = pa; enq_data = d; enq_byte_mask = m;
    @(posedge CLK); #1;
    enq_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(name, 64'(empty), 64'(1));
  endtask

  // Monitor: a drain happens on the next rising edge whenever valid & ready overlap.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST && |(bank_req_valid & bank_req_ready)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_drain: got PA 0x%0h expected no drain", bank_req_PA);
        end else begin
          e = exp_q.pop_front();
          chk("drain_pa",   64'(bank_req_PA),        64'(e.pa));
          chk("drain_data", 64'(bank_req_data),      64'(e.data));
          chk("drain_mask", 64'(bank_req_byte_mask), 64'(e.mask));
          chk("drain_bank", 64'(bank_req_valid),     64'(e.pa[5] ? 2'b10 : 2'b01));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    nRST = 1'b0; enq_valid = 1'b0; enq_PA = '0; enq_data = '0; enq_byte_mask = '0;
    bank_req_ready = 2'b00; fwd_PA = 32'hFFFF_FFF0;
    #3;
    chk("rst_empty",     64'(empty),          64'(1));
    chk("rst_count",     64'(count),          64'(0));
    chk("rst_enq_ready", 64'(enq_ready),      64'(1));
    chk("rst_bank_vld",  64'(bank_req_valid), 64'(0));
    chk("rst_fwd_mask",  64'(fwd_byte_mask),  64'(0));
    chk("rst_fwd_data",  64'(fwd_data),       64'(0));
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Two banks drain in program order.
    push(32'h0000_0040, 32'hDEAD_BEEF, 4'hF); enq(32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
    push(32'h0000_0060, 32'h0BAD_F00D, 4'hF); enq(32'h0000_0060, 32'h0BAD_F00D, 4'hF);
    chk("two_count", 64'(count), 64'(2));
    chk("two_bank0_first", 64'(bank_req_valid), 64'(2'b01));
    bank_req_ready = 2'b11;
    wait_empty("two_drain_empty");
    chk("two_count_zero", 64'(count), 64'(0));
    bank_req_ready = 2'b00;

    // Fill to capacity, then release exactly one drain.
    for (int i = 0; i < 8; i++) begin
      push(32'h0000_1000 + 32'(i) * 32'h20, 32'h1000_0000 + 32'(i), 4'hF);
      enq(32'h0000_1000 + 32'(i) * 32'h20, 32'h1000_0000 + 32'(i), 4'hF);
    end
    chk("full_count",     64'(count),     64'(8));
    chk("full_enq_ready", 64'(enq_ready), 64'(0));
    bank_req_ready = 2'b11;
    @(posedge CLK); #1;
    bank_req_ready = 2'b00;
    chk("release_count",     64'(count),     64'(7));
    chk("release_enq_ready", 64'(enq_ready), 64'(1));
    bank_req_ready = 2'b11;
    wait_empty("full_drain_empty");
    bank_req_ready = 2'b00;

    // Same-word stores behind a different head entry.
    push(32'h0000_0100, 32'hA0A0_A0A0, 4'hF);
    enq(32'h0000_0100, 32'hA0A0_A0A0, 4'hF);
`ifdef DCACHE_WB_COALESCE_EN
    push(32'h0000_0204, 32'hAABB_1122, 4'hF);
`else
    push(32'h0000_0204, 32'h0000_1122, 4'b0011);
    push(32'h0000_0204, 32'hAABB_0000, 4'b1100);
`endif
    enq(32'h0000_0204, 32'h0000_1122, 4'b0011);
    enq(32'h0000_0204, 32'hAABB_0000, 4'b1100);
`ifdef DCACHE_WB_COALESCE_EN
    chk("coalesce_count", 64'(count), 64'(2));
`else
    chk("no_coalesce_count", 64'(count), 64'(3));
`endif
    bank_req_ready = 2'b11;
    wait_empty("coalesce_drain_empty");
    bank_req_ready = 2'b00;

    // Forwarding: youngest match per byte.
    push(32'h0000_0300, 32'h1111_1111, 4'hF); enq(32'h0000_0300, 32'h1111_1111, 4'hF);
    push(32'h0000_0300, 32'h2200_0000, 4'h8); enq(32'h0000_0300, 32'h2200_0000, 4'h8);
    chk("fwd_count", 64'(count), 64'(2));
    fwd_PA = 32'h0000_0300; #1;
    chk("fwd_hit_data", 64'(fwd_data),      64'(32'h2211_1111));
    chk("fwd_hit_mask", 64'(fwd_byte_mask), 64'(4'hF));
    fwd_PA = 32'h0000_0302; #1;
    chk("fwd_byteoff_data", 64'(fwd_data), 64'(32'h2211_1111));
    fwd_PA = 32'h0000_0304; #1;
    chk("fwd_miss_mask", 64'(fwd_byte_mask), 64'(0));
    chk("fwd_miss_data", 64'(fwd_data),      64'(0));

    // Same-cycle enqueue is not visible until it is written.
    fwd_PA = 32'h0000_0400;
    enq_valid = 1'b1; enq_PA = 32'h0000_0400; enq_data = 32'h5A5A_5A5A; enq_byte_mask = 4'hF;
    #1;
    chk("fwd_same_cycle_mask", 64'(fwd_byte_mask), 64'(0));
    push(32'h0000_0400, 32'h5A5A_5A5A, 4'hF);
    @(posedge CLK); #1;
    enq_valid = 1'b0;
    chk("fwd_after_write_data", 64'(fwd_data), 64'(32'h5A5A_5A5A));

    // Asynchronous reset while a bank request is stalled.
    chk("stall_bank_vld", 64'(bank_req_valid), 64'(2'b01));
    chk("stall_pa",       64'(bank_req_PA),    64'(32'h0000_0300));
    #1;
    chk("stall_pa_held",  64'(bank_req_PA),    64'(32'h0000_0300));
    #1;
    nRST = 1'b0;
    #1;
    chk("async_bank_vld",  64'(bank_req_valid), 64'(0));
    chk("async_empty",     64'(empty),          64'(1));
    chk("async_count",     64'(count),          64'(0));
    chk("async_enq_ready", 64'(enq_ready),      64'(1));
    chk("async_fwd_mask",  64'(fwd_byte_mask),  64'(0));
    chk("async_fwd_data",  64'(fwd_data),       64'(0));
    exp_q.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Buffer is usable again after reset.
    push(32'h0000_0060, 32'hCAFE_0001, 4'h3); enq(32'h0000_0060, 32'hCAFE_0001, 4'h3);
    chk("post_rst_bank1", 64'(bank_req_valid), 64'(2'b10));
    bank_req_ready = 2'b10;
    wait_empty("post_rst_drain_empty");
    bank_req_ready = 2'b00;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
